// File: rtl/virtual_interface_host.sv
// -----------------------------------------------------------------------------
// virtual_interface_host
//
// Host side of a virtual button/LED panel carried over a pair of 8N1 UART links.
//   - TX path: sends the 24-bit button vector as three back-to-back bytes
//     (buttons[7:0], buttons[15:8], buttons[23:16]). A packet is started by a
//     one-cycle send request or, when SEND_ON_CHANGE is set, whenever the
//     buttons differ from the last snapshot sent. Requests arriving while a
//     packet is in flight collapse into a single pending packet.
//   - RX path: receives single LED bytes from the device; a good stop bit
//     updates leds and pulses leds_valid, a bad one pulses frame_error.
//   The two paths share only the clock and reset.
//
// Parameters
//   CLKS_PER_BIT    clock cycles per UART bit (4 or more)
//   SEND_ON_CHANGE  start a packet automatically when buttons change
//
// Ports
//   CLK          clock, all logic on the rising edge
//   RST          synchronous active-high reset
//   RX           UART line from the device LED transmitter (idles high)
//   TX           UART line to the device button receiver (idles high)
//   buttons      button state to transmit
//   send         one-cycle transmit request
//   busy         high while a button packet is in flight or pending
//   leds         last LED byte received with a valid stop bit
//   leds_valid   one-cycle pulse when leds updates
//   frame_error  one-cycle pulse on a bad RX stop bit
// -----------------------------------------------------------------------------
module virtual_interface_host #(
    parameter int CLKS_PER_BIT   = 870,
    parameter bit SEND_ON_CHANGE = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RX,
    output logic        TX,
    input  logic [23:0] buttons,
    input  logic        send,
    output logic        busy,
    output logic [7:0]  leds,
    output logic        leds_valid,
    output logic        frame_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    // -------------------------------------------------------------------------
    // TX path
    // -------------------------------------------------------------------------
    uart_state_t      tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [1:0]       tx_byte_idx;
    logic [2:0]       tx_bit_idx;
    logic [23:0]      tx_shift;     // packet snapshot, consumed LSB first
    logic [23:0]      last_sent;
    logic             pending;
    logic             trigger;
    logic             tx_bit_end;

    // Triggers are ignored during reset so busy reads low while RST is held.
    assign trigger    = !RST && (send || (SEND_ON_CHANGE && (buttons != last_sent)));
    assign tx_bit_end = (tx_cnt == BIT_LAST);

    // busy must already be high in the trigger cycle, before the FSM leaves
    // IDLE, so the trigger term is combined in directly.
    assign busy = (tx_state != IDLE) || pending || trigger;

    // NOTE: state is updated with non-blocking assignments so every register
    // in this block samples the pre-edge values, regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_state    <= IDLE;
            TX          <= 1'b1;
            tx_cnt      <= '0;
            tx_byte_idx <= '0;
            tx_bit_idx  <= '0;
            tx_shift    <= '0;
            last_sent   <= '0;
            pending     <= 1'b0;
        end else begin
            if (tx_state != IDLE) begin
                tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
                if (trigger) begin
                    pending <= 1'b1;
                end
            end

            case (tx_state)
                IDLE: begin
                    if (trigger || pending) begin
                        tx_state    <= START;
                        TX          <= 1'b0;
                        tx_shift    <= buttons;
                        last_sent   <= buttons;
                        pending     <= 1'b0;
                        tx_cnt      <= '0;
                        tx_byte_idx <= '0;
                        tx_bit_idx  <= '0;
                    end
                end
                START: begin
                    if (tx_bit_end) begin
                        tx_state <= DATA;
                        TX       <= tx_shift[0];
                    end
                end
                DATA: begin
                    if (tx_bit_end) begin
                        // After eight shifts the next byte sits in bit 0.
                        tx_shift <= tx_shift >> 1;
                        if (tx_bit_idx == 3'd7) begin
                            tx_state   <= STOP;
                            tx_bit_idx <= '0;
                            TX         <= 1'b1;
                        end else begin
                            tx_bit_idx <= tx_bit_idx + 1'b1;
                            TX         <= tx_shift[1];
                        end
                    end
                end
                STOP: begin
                    if (tx_bit_end) begin
                        if (tx_byte_idx == 2'd2) begin
                            tx_state <= IDLE;
                        end else begin
                            tx_byte_idx <= tx_byte_idx + 1'b1;
                            tx_state    <= START;
                            TX          <= 1'b0;
                        end
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // RX path
    // -------------------------------------------------------------------------
    uart_state_t      rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit_idx;
    logic [7:0]       rx_shift;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic             rx_wait_high;   // bad stop seen, hold until line idles
    logic             rx_fall;

    assign rx_fall = rx_prev && !rx_sync;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_prev      <= 1'b1;
            rx_state     <= IDLE;
            rx_cnt       <= '0;
            rx_bit_idx   <= '0;
            rx_shift     <= '0;
            rx_wait_high <= 1'b0;
            leds         <= 8'h00;
            leds_valid   <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            rx_meta     <= RX;
            rx_sync     <= rx_meta;
            rx_prev     <= rx_sync;
            leds_valid  <= 1'b0;
            frame_error <= 1'b0;

            case (rx_state)
                IDLE: begin
                    if (rx_fall) begin
                        rx_state <= START;
                        rx_cnt   <= '0;
                    end
                end
                START: begin
                    // Mid-start-bit check; a high line here was only a glitch.
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        if (!rx_sync) begin
                            rx_state   <= DATA;
                            rx_bit_idx <= '0;
                        end else begin
                            rx_state <= IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit_idx == 3'd7) begin
                            rx_state <= STOP;
                        end else begin
                            rx_bit_idx <= rx_bit_idx + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (rx_wait_high) begin
                        if (rx_sync) begin
                            rx_wait_high <= 1'b0;
                            rx_state     <= IDLE;
                        end
                    end else if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rx_sync) begin
                            leds       <= rx_shift;
                            leds_valid <= 1'b1;
                            rx_state   <= IDLE;
                        end else begin
                            frame_error  <= 1'b1;
                            rx_wait_high <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_virtual_interface_host.sv
// -----------------------------------------------------------------------------
// tb_virtual_interface_host
//
// Directed bench for virtual_interface_host with CLKS_PER_BIT = 4.
// Expected TX frames and LED bytes are queued when stimulus is applied; the
// TX line monitor and the leds_valid monitor pop and compare them as the DUT
// produces output.
// -----------------------------------------------------------------------------
module tb_virtual_interface_host;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        tx;
    logic [23:0] buttons;
    logic        send;
    logic        busy;
    logic [7:0]  leds;
    logic        leds_valid;
    logic        frame_error;

    int checks = 0;
    int errors = 0;
    int lv_count = 0;
    int fe_count = 0;

    logic [9:0] exp_tx_q[$];     // {stop, data[7:0], start}
    logic [7:0] exp_leds_q[$];

    virtual_interface_host #(
        .CLKS_PER_BIT   (CPB),
        .SEND_ON_CHANGE (1'b1)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .RX          (rx),
        .TX          (tx),
        .buttons     (buttons),
        .send        (send),
        .busy        (busy),
        .leds        (leds),
        .leds_valid  (leds_valid),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic push_packet(input logic [23:0] value);
        exp_tx_q.push_back({1'b1, value[7:0],   1'b0});
        exp_tx_q.push_back({1'b1, value[15:8],  1'b0});
        exp_tx_q.push_back({1'b1, value[23:16], 1'b0});
    endtask

    // Device-side LED transmitter; gives up and idles the line on reset.
    task automatic drive_rx(input logic [7:0] data, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rx = bits[b];
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (rst) begin
                    rx = 1'b1;
                    return;
                end
            end
        end
        rx = 1'b1;
    endtask

    // TX line monitor: samples one cycle into each bit, compares whole frames.
    initial begin : tx_monitor
        int         t;
        bit         active;
        logic [9:0] frame;
        logic [9:0] expected;
        t      = 0;
        active = 1'b0;
        frame  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    t      = 0;
                end
            end else begin
                t++;
                if ((t - 1) % CPB == 0) begin
                    frame[(t - 1) / CPB] = tx;
                end
                if (t == 1 + 9 * CPB) begin
                    active = 1'b0;
                    if (exp_tx_q.size() == 0) begin
                        check("tx_unexpected_frame", 32'(exp_tx_q.size()), 32'd1);
                    end else begin
                        expected = exp_tx_q.pop_front();
                        check("tx_frame", 32'(frame), 32'(expected));
                    end
                end
            end
        end
    end

    // RX result monitor: counts pulses and checks each leds update.
    initial begin : rx_monitor
        logic [7:0] expected;
        forever begin
            @(negedge clk);
            if (frame_error === 1'b1) begin
                fe_count++;
            end
            if (leds_valid === 1'b1) begin
                lv_count++;
                if (exp_leds_q.size() == 0) begin
                    check("rx_unexpected_valid", 32'(exp_leds_q.size()), 32'd1);
                end else begin
                    expected = exp_leds_q.pop_front();
                    check("rx_leds", 32'(leds), 32'(expected));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stimulus
        int n;
        int lat;
        int pulses;
        int lv0;
        int fe0;

        rst     = 1'b1;
        rx      = 1'b1;
        send    = 1'b0;
        buttons = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_leds", 32'(leds), 32'h00);
        check("rst_leds_valid", 32'(leds_valid), 32'd0);
        check("rst_frame_error", 32'(frame_error), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_tx", 32'(tx), 32'd1);

        // Send request: 3 bytes, busy for the trigger cycle plus 30 bit-times
        buttons = 24'hA5C301;
        send    = 1'b1;
        push_packet(24'hA5C301);
        #1;
        check("t1_tx_high_in_trigger_cycle", 32'(tx), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
            send = 1'b0;
            #1;
            if (n == 1) check("t1_tx_start_latency", 32'(tx), 32'd0);
        end
        check("t1_busy_cycles", 32'(n), 32'd121);
        repeat (4) @(negedge clk);

        // Good RX byte, with latency bound from the first edge seeing the low line
        exp_leds_q.push_back(8'h3C);
        pulses = 0;
        lat    = 0;
        fork
            drive_rx(8'h3C, 1'b1);
            begin
                @(posedge clk);
                for (int i = 1; i <= 48; i++) begin
                    @(posedge clk);
                    #1;
                    if (leds_valid === 1'b1) begin
                        pulses++;
                        if (lat == 0) lat = i;
                    end
                end
            end
        join
        check("t2_leds_valid_once", 32'(pulses), 32'd1);
        check("t2_latency_within_40", 32'(lat >= 1 && lat <= 40), 32'd1);
        check("t2_leds", 32'(leds), 32'h3C);

        // Bad stop bit
        lv0 = lv_count;
        fe0 = fe_count;
        @(negedge clk);
        drive_rx(8'h5A, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check("t3_frame_error_once", 32'(fe_count - fe0), 32'd1);
        check("t3_no_leds_valid", 32'(lv_count - lv0), 32'd0);
        check("t3_leds_held", 32'(leds), 32'h3C);

        // Two button changes during a packet collapse into one follow-up packet
        @(negedge clk);
        buttons = 24'h123456;
        push_packet(24'h123456);
        push_packet(24'h0F1E2D);
        #1;
        n = 0;
        while (busy === 1'b1 && n < 600) begin
            n++;
            @(negedge clk);
            if (n == 10) buttons = 24'hABCDEF;
            if (n == 20) buttons = 24'h0F1E2D;
            #1;
        end
        check("t4_busy_cycles", 32'(n), 32'd242);

        // Short low glitch on RX, then a normal byte
        lv0 = lv_count;
        fe0 = fe_count;
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_glitch_no_valid", 32'(lv_count - lv0), 32'd0);
        check("t5_glitch_no_frame_error", 32'(fe_count - fe0), 32'd0);
        exp_leds_q.push_back(8'hC6);
        drive_rx(8'hC6, 1'b1);
        repeat (4) @(negedge clk);
        check("t5_after_glitch_valid", 32'(lv_count - lv0), 32'd1);
        check("t5_leds", 32'(leds), 32'hC6);

        // Reset during the second TX byte while an RX byte is arriving
        lv0 = lv_count;
        fe0 = fe_count;
        @(negedge clk);
        buttons = 24'h00FF81;
        exp_tx_q.push_back({1'b1, 8'h81, 1'b0});
        fork
            begin
                repeat (55) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("t6_tx_high_after_rst", 32'(tx), 32'd1);
                check("t6_busy_low_in_rst", 32'(busy), 32'd0);
                check("t6_leds_cleared", 32'(leds), 32'h00);
                repeat (2) @(negedge clk);
            end
            begin
                repeat (30) @(negedge clk);
                drive_rx(8'h99, 1'b1);
            end
        join
        // Non-zero buttons after reset start a packet straight away
        push_packet(24'h00FF81);
        rst = 1'b0;
        #1;
        check("t6_busy_on_release", 32'(busy), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("t6_busy_cycles", 32'(n), 32'd121);
        check("t6_no_leds_valid", 32'(lv_count - lv0), 32'd0);
        check("t6_no_frame_error", 32'(fe_count - fe0), 32'd0);
        exp_leds_q.push_back(8'h42);
        @(negedge clk);
        drive_rx(8'h42, 1'b1);
        repeat (4) @(negedge clk);
        check("t6_rx_after_reset", 32'(leds), 32'h42);

        repeat (50) @(negedge clk);
        check("end_busy_low", 32'(busy), 32'd0);
        check("end_tx_queue_empty", 32'(exp_tx_q.size()), 32'd0);
        check("end_leds_queue_empty", 32'(exp_leds_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/virtual_interface_host.md
VIRTUAL_INTERFACE_HOST -- requirements
Module: virtual_interface_host

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 870, meaning clock cycles per UART bit, legal range 4 or more.
REQ-002 SHALL have parameter SEND_ON_CHANGE, default 1'b1, meaning a button packet starts automatically whenever the buttons vector changes.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port RX, input, 1 bit: UART line from the device-side LED transmitter; idles high.
REQ-006 SHALL have port TX, output, 1 bit: UART line to the device-side button receiver; idles high.
REQ-007 SHALL have port buttons, input, 24 bits: button state to transmit.
REQ-008 SHALL have port send, input, 1 bit: one-cycle request to transmit a button packet.
REQ-009 SHALL have port busy, output, 1 bit: high while a button packet is in flight or pending.
REQ-010 SHALL have port leds, output, 8 bits: last LED byte received correctly.
REQ-011 SHALL have port leds_valid, output, 1 bit: one-cycle pulse when leds updates.
REQ-012 SHALL have port frame_error, output, 1 bit: one-cycle pulse on a bad RX stop bit.

Function
REQ-013 UART format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-014 Button packet SHALL be 3 back-to-back bytes in this order: buttons[7:0], buttons[15:8], buttons[23:16]; 30 bit-times total, with no idle between bytes.
REQ-015 The buttons vector SHALL be snapshotted in the cycle the packet starts; later changes SHALL NOT alter the packet in flight.
REQ-016 TX FSM states SHALL be IDLE, START, DATA, STOP, plus a 2-bit byte index (0..2) and a 3-bit bit index.
REQ-017 TX SHALL go IDLE->START on trigger; START->DATA after CLKS_PER_BIT; DATA->STOP after the 8th bit; STOP->START if byte index < 2, else IDLE.
REQ-018 TX trigger SHALL be: send high, or (SEND_ON_CHANGE and buttons differs from the last-sent snapshot).
REQ-019 TX line SHALL go low on the cycle after the trigger cycle (1-cycle latency).
REQ-020 A trigger arriving while not IDLE SHALL set a pending flag; on return to IDLE with pending set, a new packet SHALL start the next cycle using the fresh snapshot, and pending SHALL clear.
REQ-021 Multiple triggers during one packet SHALL collapse into one pending packet.
REQ-022 busy SHALL be high from the trigger cycle until the last stop bit ends with no pending packet.
REQ-023 RX SHALL pass through a 2-flop synchronizer before use, adding 2 cycles of latency.
REQ-024 RX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-025 RX IDLE->START SHALL occur on a synchronized falling edge of the line.
REQ-026 In RX START, the line SHALL be sampled at CLKS_PER_BIT/2 (integer division); if low, go to DATA; if high, treat as a glitch and return to IDLE with no pulse.
REQ-027 In RX DATA, a bit SHALL be sampled every CLKS_PER_BIT cycles from the start-bit midpoint, LSB first; go to STOP after 8 bits.
REQ-028 At the STOP sample, a high line SHALL load leds and pulse leds_valid for 1 cycle; a low line SHALL pulse frame_error, leave leds unchanged, and return to IDLE only after the line returns high.
REQ-029 RX and TX SHALL be fully independent; simultaneous activity SHALL not interact.
REQ-030 Counters SHALL be sized to ceil(log2(CLKS_PER_BIT)) bits and reset to 0 at every bit boundary, with no wrap-around beyond CLKS_PER_BIT-1.

Reset
REQ-031 RST high at a clock edge SHALL force: TX=1, busy=0, leds=8'h00, leds_valid=0, frame_error=0, both FSMs IDLE, pending=0, last-sent snapshot=24'h000000.
REQ-032 RST asserted mid-packet SHALL abort immediately; TX SHALL return high the next cycle, and no partial byte SHALL be reported on RX.
REQ-033 After reset deasserts with buttons non-zero and SEND_ON_CHANGE=1, a packet SHALL start on the first cycle.

Verification (CLKS_PER_BIT=4)
REQ-034 buttons=24'hA5C301, pulse send -> TX sends bytes 01, C3, A5 in 8N1 format; busy high for 1+120 cycles, then low.
REQ-035 Device drives RX byte 8'h3C with a valid stop bit -> leds=8'h3C and leds_valid pulses once, within 2+38 cycles of the start-bit falling edge.
REQ-036 RX byte with stop bit 0 -> frame_error pulses once; leds keeps its previous value; no leds_valid pulse.
REQ-037 buttons changes twice during a packet (SEND_ON_CHANGE=1) -> exactly one extra packet follows, carrying the final value, starting 1 cycle after the first packet ends.
REQ-038 2-cycle low glitch on RX -> no leds_valid and no frame_error; RX returns to IDLE.
REQ-039 RST during byte 2 of a TX packet while RX is receiving -> TX high next cycle; leds=00; no pulses; normal operation afterwards.
